// File: rtl/uart_frame_pkg.sv
// Shared constants for the UART frame deframer: delimiter byte, error codes and
// one-hot state encodings.
package uart_frame_pkg;

    localparam logic [7:0] SOF_CHAR = 8'h26;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_TIMEOUT  = 2'b01,
        ERR_OVERFLOW = 2'b10,
        ERR_OVERRUN  = 2'b11
    } err_e;

    typedef logic [4:0] state_t;

    localparam state_t ST_IDLE    = 5'b00001;
    localparam state_t ST_SOF2    = 5'b00010;
    localparam state_t ST_PAYLOAD = 5'b00100;
    localparam state_t ST_EOF2    = 5'b01000;
    localparam state_t ST_HOLD    = 5'b10000;

    // Inter-byte silence limit in clock cycles (10 bits per character).
    function automatic longint calc_timeout_clk(longint bytes, longint clk_hz, longint baud);
        return (bytes * 64'd10 * clk_hz) / baud;
    endfunction

endpackage

// File: rtl/frame_buf.sv
// Payload store: simple dual-port RAM with synchronous write and a registered,
// resettable read port.
module frame_buf #(
    parameter int DEPTH = 129,
    parameter int AW    = 8
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_frame_deframer.sv
// Extracts &&payload&& frames from the UART byte stream, holds the payload until
// acknowledged, and flags timeout, overflow and overrun errors.
module uart_frame_deframer
    import uart_frame_pkg::*;
#(
    parameter int CLK_FREQ      = 50_000_000,
    parameter int BAUD_RATE     = 115_200,
    parameter int MAX_LEN       = 128,
    parameter int TIMEOUT_BYTES = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_vld,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [7:0] frame_len,
    output logic       frame_done,
    input  logic       frame_ack,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int     AW          = $clog2(MAX_LEN + 1);
    // The pointer can reach MAX_LEN+1 once a trailing '&' candidate is stored.
    localparam int     PW          = $clog2(MAX_LEN + 2);
    localparam longint TO_L        = calc_timeout_clk(TIMEOUT_BYTES, CLK_FREQ, BAUD_RATE);
    localparam int     TIMEOUT_CLK = int'(TO_L);
    localparam int     CNT_W       = $clog2(TIMEOUT_CLK + 1);

    state_t             state_q, state_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         frame_len_q, frame_len_d;
    logic               frame_done_q, frame_done_d;
    logic               frame_err_q, frame_err_d;
    logic [1:0]         err_code_q, err_code_d;
    logic               wr_en;
    logic               is_sof, in_frame, in_body, timeout_hit, ovf_hit;
    logic               unused_rd_hi;

    assign is_sof      = (rx_data == SOF_CHAR);
    assign in_frame    = (state_q == ST_SOF2) || (state_q == ST_PAYLOAD) || (state_q == ST_EOF2);
    assign in_body     = (state_q == ST_PAYLOAD) || (state_q == ST_EOF2);
    assign timeout_hit = in_frame && !rx_vld && (cnt_q == CNT_W'(TIMEOUT_CLK - 1));
    // A non-'&' byte always extends the payload; '&' may still be a closing delimiter.
    assign ovf_hit     = in_body && rx_vld && !is_sof && (wr_ptr_q >= PW'(MAX_LEN));

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            cnt_q        <= '0;
            frame_len_q  <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
            frame_len_q  <= frame_len_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            err_code_q   <= err_code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_vld && is_sof) state_d = ST_SOF2;
            end
            ST_SOF2: begin
                if (timeout_hit)  state_d = ST_IDLE;
                else if (rx_vld)  state_d = is_sof ? ST_PAYLOAD : ST_IDLE;
            end
            ST_PAYLOAD: begin
                if (timeout_hit || ovf_hit) state_d = ST_IDLE;
                else if (rx_vld && is_sof)  state_d = ST_EOF2;
            end
            ST_EOF2: begin
                if (timeout_hit || ovf_hit) state_d = ST_IDLE;
                else if (rx_vld)            state_d = is_sof ? ST_HOLD : ST_PAYLOAD;
            end
            ST_HOLD: begin
                if (frame_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_en        = 1'b0;
        wr_ptr_d     = wr_ptr_q;
        cnt_d        = '0;
        frame_len_d  = frame_len_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        err_code_d   = err_code_q;

        if (in_frame && !rx_vld && !timeout_hit) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (timeout_hit) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
        end

        if (state_q == ST_SOF2 && rx_vld && is_sof) begin
            wr_ptr_d = '0;
        end

        if (in_body && rx_vld) begin
            if (ovf_hit) begin
                frame_err_d = 1'b1;
                err_code_d  = ERR_OVERFLOW;
            end else if (state_q == ST_EOF2 && is_sof) begin
                frame_done_d = 1'b1;
                frame_len_d  = 8'(wr_ptr_q - PW'(1));
            end else begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
        end

        if (state_q == ST_HOLD && rx_vld) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_OVERRUN;
        end
    end

    frame_buf #(
        .DEPTH (MAX_LEN + 1),
        .AW    (AW)
    ) u_buf (
        .clk_i   (sys_clk),
        .rst_n_i (sys_rst_n),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (rx_data),
        .raddr_i (rd_addr[AW-1:0]),
        .rdata_o (rd_data)
    );

    // Address bits above the buffer depth only select undefined bytes.
    assign unused_rd_hi = ^rd_addr;

    assign frame_len  = frame_len_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign err_code   = err_code_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_frame_deframer.sv
// Directed bench for uart_frame_deframer with a byte-queue reference model
// compared against the outputs every cycle.
module tb_uart_frame_deframer;

    localparam int        MAX_LEN = 4;
    localparam int        TO_CLK  = 200;   // 2 bytes * 10 bits * 1000 Hz / 100 baud
    localparam logic [7:0] AMP    = 8'h26;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic [7:0] rx_data;
    logic       rx_vld;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] frame_len;
    logic       frame_done;
    logic       frame_ack;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;

    uart_frame_deframer #(
        .CLK_FREQ      (1000),
        .BAUD_RATE     (100),
        .MAX_LEN       (MAX_LEN),
        .TIMEOUT_BYTES (2)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .rx_data    (rx_data),
        .rx_vld     (rx_vld),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .frame_len  (frame_len),
        .frame_done (frame_done),
        .frame_ack  (frame_ack),
        .frame_err  (frame_err),
        .err_code   (err_code),
        .busy       (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    // Reference model: 0 idle, 1 one '&' seen, 2 collecting, 3 holding
    int         mode = 0;
    int         sil  = 0;
    bit         model_on = 0;
    logic [7:0] pay[$];
    logic [7:0] held[$];
    logic       exp_done, exp_err;
    logic [1:0] exp_code;
    logic [7:0] exp_len, exp_rd;
    bit         rd_ok;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_step();
        logic [7:0] d;
        d = rx_data;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (!sys_rst_n) begin
            mode = 0; sil = 0; pay.delete();
            exp_len = 8'd0; exp_code = 2'd0; exp_rd = 8'd0; rd_ok = 1'b1;
            model_on = 1'b1;
        end else begin
            if (mode == 1 || mode == 2) begin
                if (rx_vld) begin
                    sil = 0;
                    if (mode == 1) begin
                        if (d == AMP) begin mode = 2; pay.delete(); end
                        else mode = 0;
                    end else if (d == AMP && pay.size() > 0 && pay[$] == AMP) begin
                        held = pay;
                        void'(held.pop_back());
                        exp_len  = 8'(held.size());
                        exp_done = 1'b1;
                        mode     = 3;
                    end else if (d != AMP && pay.size() + 1 > MAX_LEN) begin
                        exp_err = 1'b1; exp_code = 2'b10; mode = 0;
                    end else begin
                        pay.push_back(d);
                    end
                end else begin
                    sil++;
                    if (sil == TO_CLK) begin
                        exp_err = 1'b1; exp_code = 2'b01; mode = 0; sil = 0;
                    end
                end
            end else if (mode == 0) begin
                if (rx_vld && d == AMP) begin mode = 1; sil = 0; end
            end else begin
                if (rx_vld) begin exp_err = 1'b1; exp_code = 2'b11; end
                if (frame_ack) mode = 0;
            end
            rd_ok = (mode == 3) && (int'(rd_addr) < held.size());
            if (rd_ok) exp_rd = held[rd_addr];
        end
    endtask

    task automatic compare_step();
        if (model_on) begin
            chk("frame_done", frame_done, exp_done);
            chk("frame_err", frame_err, exp_err);
            chk("err_code", err_code, exp_code);
            chk("frame_len", frame_len, exp_len);
            chk("busy", busy, mode != 0);
            if (rd_ok) chk("rd_data", rd_data, exp_rd);
            if (frame_done) done_cnt++;
            if (frame_err) err_cnt++;
        end
    endtask

    initial forever begin
        @(posedge sys_clk);
        model_step();
    end

    initial forever begin
        @(negedge sys_clk);
        compare_step();
    end

    task automatic wait_edge();
        @(posedge sys_clk);
        #2;
    endtask

    // gap = idle cycles between bytes; 0 gives back-to-back strobes
    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            wait_edge();
            rx_data = s[i];
            rx_vld  = 1'b1;
            if (gap > 0) begin
                wait_edge();
                rx_vld = 1'b0;
                repeat (gap - 1) wait_edge();
            end
        end
        if (gap == 0) begin
            wait_edge();
            rx_vld = 1'b0;
        end
    endtask

    task automatic rd_chk(input int a, input logic [7:0] exp, input string nm);
        rd_addr = 8'(a);
        wait_edge();
        chk(nm, rd_data, exp);
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        wait_edge();
        frame_ack = 1'b0;
        wait_edge();
    endtask

    int d0, e0;

    initial begin
        sys_rst_n = 1'b0;
        rx_vld    = 1'b0;
        rx_data   = 8'h00;
        frame_ack = 1'b0;
        rd_addr   = 8'h00;
        repeat (3) wait_edge();
        chk("rst_len", frame_len, 8'd0);
        chk("rst_code", err_code, 2'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_err", frame_err, 1'b0);
        chk("rst_rd", rd_data, 8'd0);
        sys_rst_n = 1'b1;
        wait_edge();

        // Leading junk and an aborted start are ignored
        d0 = done_cnt;
        send_str("x&x&&AB&&", 1);
        wait_edge(); wait_edge();
        chk("ab_done_once", done_cnt - d0, 1);
        chk("ab_len", frame_len, 8'd2);
        chk("ab_busy", busy, 1'b1);
        rd_chk(0, 8'h41, "ab_rd0");
        rd_chk(1, 8'h42, "ab_rd1");
        ack();
        chk("ab_busy_after_ack", busy, 1'b0);

        // Embedded single '&', back-to-back strobes
        send_str("&&A&B&&", 0);
        wait_edge();
        chk("amp_len", frame_len, 8'd3);
        rd_chk(0, 8'h41, "amp_rd0");
        rd_chk(1, 8'h26, "amp_rd1");
        rd_chk(2, 8'h42, "amp_rd2");
        ack();

        d0 = done_cnt;
        send_str("&&&&", 1);
        wait_edge(); wait_edge();
        chk("empty_done", done_cnt - d0, 1);
        chk("empty_len", frame_len, 8'd0);
        ack();

        send_str("&&ABCD&&", 1);
        wait_edge();
        chk("max_len", frame_len, 8'd4);
        rd_chk(3, 8'h44, "max_rd3");
        ack();

        d0 = done_cnt; e0 = err_cnt;
        send_str("&&ABCDE", 1);
        wait_edge(); wait_edge();
        chk("ovf_code", err_code, 2'b10);
        chk("ovf_err_once", err_cnt - e0, 1);
        chk("ovf_no_done", done_cnt - d0, 0);
        chk("ovf_busy", busy, 1'b0);

        // Overflow triggered from the embedded-'&' state
        send_str("&&&&", 1);
        ack();
        e0 = err_cnt;
        send_str("&&ABC&E", 1);
        wait_edge(); wait_edge();
        chk("ovf2_code", err_code, 2'b10);
        chk("ovf2_err", err_cnt - e0, 1);

        // Silence one cycle short of the limit keeps the frame alive
        e0 = err_cnt;
        send_str("&&A", 0);
        repeat (TO_CLK - 2) wait_edge();
        send_str("&&", 0);
        wait_edge();
        chk("near_to_err", err_cnt - e0, 0);
        chk("near_to_len", frame_len, 8'd1);
        ack();

        d0 = done_cnt; e0 = err_cnt;
        send_str("&&A", 0);
        repeat (TO_CLK + 3) wait_edge();
        chk("to_err_once", err_cnt - e0, 1);
        chk("to_code", err_code, 2'b01);
        chk("to_busy", busy, 1'b0);
        chk("to_no_done", done_cnt - d0, 0);

        // Overrun while holding
        send_str("&&AB&&", 1);
        wait_edge();
        e0 = err_cnt;
        send_str("&&Z&&", 1);
        wait_edge();
        chk("ovr_pulses", err_cnt - e0, 5);
        chk("ovr_code", err_code, 2'b11);
        chk("ovr_len", frame_len, 8'd2);
        chk("ovr_busy", busy, 1'b1);
        rd_chk(0, 8'h41, "ovr_rd0");
        rd_chk(1, 8'h42, "ovr_rd1");

        // Byte and ack in the same cycle: overrun flagged, ack honoured
        e0 = err_cnt;
        rx_data = 8'h51; rx_vld = 1'b1; frame_ack = 1'b1;
        wait_edge();
        rx_vld = 1'b0; frame_ack = 1'b0;
        wait_edge();
        chk("sim_busy", busy, 1'b0);
        chk("sim_err", err_cnt - e0, 1);

        send_str("&&Q&&", 1);
        wait_edge();
        chk("new_len", frame_len, 8'd1);
        rd_chk(0, 8'h51, "new_rd0");
        ack();

        // Reset mid-frame
        e0 = err_cnt;
        rd_addr = 8'd0;
        send_str("&&AB", 1);
        sys_rst_n = 1'b0;
        wait_edge();
        chk("mrst_len", frame_len, 8'd0);
        chk("mrst_code", err_code, 2'd0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_rd", rd_data, 8'd0);
        sys_rst_n = 1'b1;
        wait_edge();
        chk("mrst_no_err", err_cnt - e0, 0);
        send_str("&&C&&", 1);
        wait_edge();
        chk("post_rst_len", frame_len, 8'd1);
        rd_chk(0, 8'h43, "post_rst_rd0");
        ack();
        repeat (3) wait_edge();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_frame_deframer.md
# uart_frame_deframer

Receive-side framing stage between the byte-level `uart_rx` receiver and the string/command consumers. It scans the received byte stream for frames of the form `&&payload&&`, stores the payload in an internal buffer, and reports completion with the payload length. The frame is then held until the consumer acknowledges it. It also detects inter-byte timeout, payload overflow and buffer overrun.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000, system clock frequency in Hz.
- `BAUD_RATE`, 115_200, line rate; must match `uart_rx`.
- `MAX_LEN`, 128, maximum payload bytes; legal range 1..255.
- `TIMEOUT_BYTES`, 4, inter-byte silence (in 10-bit character times) that aborts a frame.

Ports:
- `sys_clk` in 1: system clock.
- `sys_rst_n` in 1: synchronous, active-low reset.
- `rx_data` in 8: byte from `uart_rx`.
- `rx_vld` in 1: one-cycle strobe; `rx_data` is valid in that cycle.
- `rd_addr` in 8: payload read address.
- `rd_data` out 8: payload byte at `rd_addr`, registered.
- `frame_len` out 8: payload length of the held frame.
- `frame_done` out 1: one-cycle pulse when a frame enters HOLD.
- `frame_ack` in 1: consumer releases the held frame.
- `frame_err` out 1: one-cycle error pulse.
- `err_code` out 2: last error; held until the next error.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Reset values: `rd_data`=0, `frame_len`=0, `frame_done`=0, `frame_err`=0, `err_code`=0, `busy`=0, state=IDLE, write pointer `wr_ptr`=0. Buffer contents are not reset.
- States are one-hot: IDLE, SOF2, PAYLOAD, EOF2, HOLD. All transitions below occur on `rx_vld` unless stated otherwise.
- IDLE:
  - `&` → SOF2.
  - Any other byte is ignored.
- SOF2:
  - `&` → PAYLOAD with `wr_ptr`=0.
  - Any other byte → IDLE, no error.
- PAYLOAD:
  - Every byte, including `&`, is written to `buf[wr_ptr]` and `wr_ptr` increments.
  - `&` → EOF2.
- EOF2:
  - `&` → HOLD. The second `&` is not written. `frame_len` ← `wr_ptr`−1 and `frame_done` pulses.
  - Any other byte is written, `wr_ptr` increments, state → PAYLOAD. A single embedded `&` is therefore kept as payload.
- Empty frame: `&&&&` gives `frame_len`=0 and still asserts `frame_done`.
- Overflow (`err_code`=2'b10):
  - Raised on any byte that would make the payload length, excluding the closing `&&`, exceed `MAX_LEN`.
  - The frame is discarded and state → IDLE.
  - The internal buffer depth is `MAX_LEN`+1 so that the trailing `&` candidate always fits.
- Timeout (`err_code`=2'b01):
  - In SOF2, PAYLOAD or EOF2, a silence counter clears on every `rx_vld` and otherwise increments.
  - When it reaches TIMEOUT_CLK = `TIMEOUT_BYTES`·10·`CLK_FREQ`/`BAUD_RATE`, the block raises the error and state → IDLE.
  - The counter is held at 0 in IDLE and HOLD.
- Overrun (`err_code`=2'b11):
  - `rx_vld` in HOLD drops the byte and raises the error; state stays HOLD.
  - The held frame and `frame_len` are not altered.
- HOLD:
  - `frame_ack` → IDLE.
  - `frame_ack` in any other state is ignored.
- Simultaneous `frame_ack` and `rx_vld` in HOLD: the byte counts as overrun and the ack is honoured, so state → IDLE.
- `err_code` priority when several errors coincide: overflow > timeout. They cannot coincide, because `rx_vld` clears the timeout counter.

## Timing
- `frame_done` is high in the cycle after the `rx_vld` of the closing `&`; `frame_len` is valid from that same cycle.
- `frame_err` is high the cycle after the triggering event; `err_code` is updated in the same cycle.
- `rd_data` has one-cycle latency from `rd_addr`. It is readable in any state, but contents are guaranteed only in HOLD.
- `rd_addr` ≥ `frame_len` returns an undefined byte.
- HOLD → IDLE takes effect the cycle after `frame_ack`. The next `&` is accepted from that cycle.
- Back-to-back `rx_vld` on consecutive cycles must be handled, even though the UART never produces them.
- Reset asserted mid-frame: the block returns to IDLE on the next clock edge, the partial frame is lost and no error is flagged.

## Structure
- Package `uart_frame_pkg` holds:
  - `SOF_CHAR` = 8'h26 (`&`).
  - Error codes `ERR_NONE`, `ERR_TIMEOUT`, `ERR_OVERFLOW`, `ERR_OVERRUN`.
  - One-hot state constants.
- Sub-module `frame_buf`: simple dual-port RAM, depth `MAX_LEN`+1, with a synchronous write port and a registered read port. It must infer block or distributed RAM.
- The top level contains the FSM, `wr_ptr`, the silence counter and the output registers.

## Test plan
- Send `x&&AB&&` → `frame_done` pulses once, `frame_len`=2, reads at 0 and 1 return 8'h41 and 8'h42, `busy`=1 until `frame_ack`.
- Send `&&A&B&&` → `frame_len`=3 and buffer = `A`,`&`,`B`. Send `&&&&` → `frame_len`=0 with `frame_done` asserted.
- Send `&&A`, then idle for TIMEOUT_CLK cycles → `frame_err` pulse, `err_code`=01, state IDLE, no `frame_done`.
- With `MAX_LEN`=4: send `&&ABCD&&` → `frame_len`=4. Send `&&ABCDE` → overflow (10) on `E`.
- With a frame held, send `&&Z&&` → five overrun pulses (11), held frame unchanged. After `frame_ack`, a new frame is accepted.
- Assert `sys_rst_n`=0 for one cycle after `&&AB` → outputs at reset values. A subsequent `&&C&&` gives `frame_len`=1.
